// File: rtl/sqrt_reconstruct_if.sv
// Handshake bundle for sqrt_reconstruct: operand pair in, reconstructed radicand out.
// The slave modport is the reconstructor; the master modport is whoever feeds and drains it.
interface sqrt_reconstruct_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   Q_i;
  logic [WIDTH:0]     R_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [2*WIDTH-1:0] D_o;
  logic               err_o;

  modport slave (
    input  in_valid_i,
    input  Q_i,
    input  R_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output D_o,
    output err_o
  );

  modport master (
    output in_valid_i,
    output Q_i,
    output R_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  D_o,
    input  err_o
  );
endinterface

// File: rtl/sqrt_reconstruct.sv
// Iterative radicand reconstructor: D = Q*Q + R, one multiplier bit per clock, MSB first,
// then one cycle to add the remainder. Results wrap modulo 2^(2*WIDTH).
// Optional remainder range check (err_o = R > 2Q) is enabled by defining
// SQRT_RECON_RANGE_CHECK_EN; otherwise err_o is tied low.
module sqrt_reconstruct #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  sqrt_reconstruct_if.slave  bus
);

  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StAddr, StDone} state_e;

  state_e            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DW-1:0]     r_acc;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_qreg;
  logic [WIDTH:0]    r_rreg;
  logic [DW-1:0]     w_add_a;
  logic [DW-1:0]     w_add_b;
  logic [DW-1:0]     w_sum;

  // Generate/propagate adder with carry-in 0; the final carry is dropped so sums wrap.
  function automatic logic [DW-1:0] cla_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] g;
    logic [DW-1:0] p;
    logic [DW-1:0] s;
    logic          carry;
    g     = a & b;
    p     = a ^ b;
    carry = 1'b0;
    for (int i = 0; i < DW; i++) begin
      s[i]  = p[i] ^ carry;
      carry = g[i] | (p[i] & carry);
    end
    return s;
  endfunction

  // Adder operand select: shifted partial product in MUL, zero-extended remainder otherwise.
  always_comb begin
    w_add_a = r_acc;
    w_add_b = '0;
    if (r_state == StMul) begin
      w_add_a = r_acc << 1;
      if (r_qreg[r_cnt]) begin
        w_add_b = {{WIDTH{1'b0}}, r_qreg};
      end
    end else begin
      w_add_b = {{(WIDTH - 1){1'b0}}, r_rreg};
    end
    w_sum = cla_add(w_add_a, w_add_b);
  end

`ifdef SQRT_RECON_RANGE_CHECK_EN
  logic r_err;
`endif

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_qreg      <= '0;
      r_rreg      <= '0;
`ifdef SQRT_RECON_RANGE_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid_i && r_in_ready) begin
            r_qreg     <= bus.Q_i;
            r_rreg     <= bus.R_i;
            r_acc      <= '0;
            r_cnt      <= CntW'(WIDTH - 1);
            r_in_ready <= 1'b0;
            r_state    <= StMul;
          end
        end
        StMul: begin
          r_acc <= w_sum;
          if (r_cnt == '0) begin
            r_state <= StAddr;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StAddr: begin
          r_acc       <= w_sum;
`ifdef SQRT_RECON_RANGE_CHECK_EN
          r_err       <= (r_rreg > {r_qreg, 1'b0});
`endif
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          // Result held until the consumer takes it.
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.D_o         = r_acc;
`ifdef SQRT_RECON_RANGE_CHECK_EN
  assign bus.err_o       = r_err;
`else
  assign bus.err_o       = 1'b0;
`endif

endmodule

// File: doc/sqrt_reconstruct.md
# sqrt_reconstruct

Iterative radicand reconstructor: takes a root Q and remainder R from the square-root datapath and rebuilds D = Q·Q + R with a shift-add multiplier, one multiplier bit per clock. It sits downstream of the square-root pipeline as its inverse path, for self-check and verification of root/remainder pairs. Valid/ready handshakes on input and output. A remainder range check is optional.

## Interface
- WIDTH, 8: root width in bits. Radicand is 2*WIDTH bits and remainder is WIDTH+1 bits.
- clk_i  in  1  clock. One clock domain; all state is updated on the rising edge.
- rst_i  in  1  reset. Asynchronous, active-high.
- in_valid_i  in  1  Q_i/R_i are valid.
- in_ready_o  out  1  block can accept an operand pair.
- Q_i  in  WIDTH  root operand, unsigned.
- R_i  in  WIDTH+1  remainder operand, unsigned.
- out_valid_o  out  1  D_o/err_o are valid.
- out_ready_i  in  1  downstream accepts the result.
- D_o  out  2*WIDTH  reconstructed radicand Q*Q+R, modulo 2^(2*WIDTH).
- err_o  out  1  R_i > 2*Q_i, so the pair is not a legal sqrt result.

## Operation
- FSM states: IDLE, MUL, ADDR, DONE.
- IDLE
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: latch Q into qreg and R into rreg; set acc=0 and cnt=WIDTH-1; go to MUL.
- MUL
  - Each cycle: acc = (acc<<1) + (qreg[cnt] ? {WIDTH'b0,qreg} : 0).
  - Bits are processed MSB first; cnt decrements.
  - After the cnt==0 cycle, go to ADDR.
- ADDR
  - acc = acc + zero-extended rreg.
  - err register = (rreg > {qreg,1'b0}), compared at WIDTH+1 bits.
  - Go to DONE.
- DONE
  - out_valid_o=1; D_o=acc; err_o=err register.
  - On out_ready_i go to IDLE.
- Both accumulate additions use the existing CLA adder at width 2*WIDTH with Ci_i=0. The carry-out is discarded, so results wrap modulo 2^(2*WIDTH).
- Legal pairs (R <= 2Q) never overflow. The maximum is (2^W-1)^2 + 2(2^W-1) = 2^(2W)-1.
- in_ready_o=1 only in IDLE. in_valid_i is ignored in MUL, ADDR and DONE, and operands are not re-latched.
- D_o and err_o are stable while out_valid_o=1 && !out_ready_i.
- Q_i and R_i may change freely after the accepting edge.

## Timing
- Reset values (asynchronous, immediate on rst_i):
  - state=IDLE, in_ready_o=1, out_valid_o=0, D_o=0, err_o=0, acc=0, cnt=0.
- Latency: with the operand accepted at edge 0, edges 1..WIDTH are MUL and edge WIDTH+1 is ADDR. out_valid_o=1 after edge WIDTH+1 (9 cycles for WIDTH=8).
- Result handshake: completes on the first edge with out_valid_o && out_ready_i. in_ready_o is 1 in the following cycle.
- Throughput with out_ready_i held 1: one result per WIDTH+3 cycles (11 for WIDTH=8). No back-to-back overlap.
- out_valid_o, in_ready_o, D_o and err_o come straight from registers and the state decode. No combinational path from inputs to outputs.
- Reset mid-operation (MUL, ADDR or DONE): return to IDLE. The in-flight result is lost and never presented. The next accepted operand pair computes correctly.

## Configuration
- SQRT_RECON_RANGE_CHECK_EN
  - Defined: err_o is computed in ADDR as specified.
  - Undefined: err_o is tied to 0, and the comparator and err register are not synthesised.
  - D_o behaviour is identical in both builds.

## Test plan
- WIDTH=8, Q=12, R=0, out_ready_i=1 -> out_valid_o rises 9 cycles after acceptance; D_o=144, err_o=0; in_ready_o=1 the following cycle.
- Q=255, R=510 -> D_o=65535, err_o=0 (maximum legal, no wrap). Q=0, R=0 -> D_o=0, err_o=0.
- Q=10, R=21 -> D_o=121, err_o=1 with the macro defined and 0 without it. Q=255, R=511 -> D_o=0 (wrap), err_o=1.
- Q=100, R=7 with out_ready_i low for 5 cycles after out_valid_o -> D_o=10007 held stable, in_ready_o=0 throughout, in_valid_i pulses ignored; completes on the first out_ready_i=1 edge.
- Assert rst_i in the 4th MUL cycle -> outputs at reset values immediately, out_valid_o never rises for that pair; next pair Q=3, R=2 -> D_o=11.
- Two back-to-back pairs (Q=7,R=1), then (Q=200,R=399) with in_valid_i held -> D_o=50, then 40399; second acceptance exactly 11 cycles after the first.
